// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, RAM and status signals of the two-port RAM arbiter
// cnt0/cnt1 exist only when ARB_ACCESS_COUNT_EN is defined.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_q;

  logic          busy;
  logic          last_grant;
`ifdef ARB_ACCESS_COUNT_EN
  logic [15:0]   cnt0;
  logic [15:0]   cnt1;
`endif

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output gnt0, ack0, rdata0,
    output gnt1, ack1, rdata1,
    output mem_we, mem_addr, mem_d,
`ifdef ARB_ACCESS_COUNT_EN
    output cnt0, cnt1,
`endif
    output busy, last_grant
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  gnt0, ack0, rdata0,
    input  gnt1, ack1, rdata1,
    input  mem_we, mem_addr, mem_d,
`ifdef ARB_ACCESS_COUNT_EN
    input  cnt0, cnt1,
`endif
    input  busy, last_grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-requester arbiter and access sequencer for a single-port RAM
// Define ARB_ACCESS_COUNT_EN to add saturating per-requester completion counters cnt0/cnt1.
module mem_arbiter #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int HOLD = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          owner_q;
  logic          last_grant_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic [HW-1:0] hold_q;
  logic          grant;
  logic          grant_idx;
  logic          hold_last;

  assign hold_last = (hold_q == HW'(HOLD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_idx = last_grant_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (bus.req0 && bus.req1) begin
          grant     = 1'b1;
          grant_idx = ~last_grant_q;
        end else if (bus.req0) begin
          grant     = 1'b1;
          grant_idx = 1'b0;
        end else if (bus.req1) begin
          grant     = 1'b1;
          grant_idx = 1'b1;
        end
        if (grant) state_d = ACCESS;
      end
      ACCESS:  if (hold_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      if (grant) begin
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
        we_q         <= grant_idx ? bus.we1    : bus.we0;
        addr_q       <= grant_idx ? bus.addr1  : bus.addr0;
        wdata_q      <= grant_idx ? bus.wdata1 : bus.wdata0;
        hold_q       <= '0;
      end
      if (state_q == ACCESS) begin
        if (!hold_last) hold_q <= hold_q + 1'b1;
        if (hold_last && !we_q) begin
          if (owner_q) rdata1_q <= bus.mem_q;
          else         rdata0_q <= bus.mem_q;
        end
      end
    end
  end

`ifdef ARB_ACCESS_COUNT_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == DONE) begin
      if (!owner_q && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
      if ( owner_q && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

  // RAM controls come only from the latched owner registers, never from live requester inputs.
  assign bus.mem_we     = (state_q == ACCESS) && we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_d      = wdata_q;

  assign bus.gnt0       = (state_q != IDLE) && !owner_q;
  assign bus.gnt1       = (state_q != IDLE) &&  owner_q;
  assign bus.ack0       = (state_q == DONE) && !owner_q;
  assign bus.ack1       = (state_q == DONE) &&  owner_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (HOLD=1 and HOLD=3 instances)
// Counter checks are compiled in when ARB_ACCESS_COUNT_EN is defined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(8), .DW(16)) b1 ();
  mem_arbiter_if #(.AW(8), .DW(16)) b3 ();

  mem_arbiter #(.AW(8), .DW(16), .HOLD(1)) u_dut  (.clk(clk), .rst(rst), .bus(b1.slave));
  mem_arbiter #(.AW(8), .DW(16), .HOLD(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  logic [15:0] ram1 [256];
  logic [15:0] ram3 [256];

  always @(posedge clk) begin
    if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_d;
    if (b3.mem_we) ram3[b3.mem_addr] <= b3.mem_d;
  end
  assign b1.mem_q = ram1[b1.mem_addr];
  assign b3.mem_q = ram3[b3.mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction on the HOLD=1 instance; returns the negedge index of the ack,
  // the number of write cycles and a count of wrong-address/foreign-grant observations.
  task automatic txn1(input bit r, input logic we, input logic [7:0] a, input logic [15:0] d,
                      output int ack_at, output int we_cnt, output int bad);
    ack_at = -1; we_cnt = 0; bad = 0;
    if (r) begin b1.req1 = 1'b1; b1.we1 = we; b1.addr1 = a; b1.wdata1 = d; end
    else   begin b1.req0 = 1'b1; b1.we0 = we; b1.addr0 = a; b1.wdata0 = d; end
    for (int c = 1; c <= 8 && ack_at < 0; c++) begin
      @(negedge clk);
      if (b1.mem_we) begin
        we_cnt++;
        if (b1.mem_addr !== a || b1.mem_d !== d) bad++;
      end
      if (r ? (b1.gnt0 || b1.ack0) : (b1.gnt1 || b1.ack1)) bad++;
      if (r ? b1.ack1 : b1.ack0) ack_at = c;
    end
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
  endtask

  int ack_at, we_cnt, bad, nacks, a20, acks;
  int order [4];
  logic lg [4];

  initial begin
    for (int i = 0; i < 256; i++) begin ram1[i] = 16'h0; ram3[i] = 16'h0; end
    rst = 1'b0;
    b1.req0 = 0; b1.we0 = 0; b1.addr0 = 0; b1.wdata0 = 0;
    b1.req1 = 0; b1.we1 = 0; b1.addr1 = 0; b1.wdata1 = 0;
    b3.req0 = 0; b3.we0 = 0; b3.addr0 = 0; b3.wdata0 = 0;
    b3.req1 = 0; b3.we1 = 0; b3.addr1 = 0; b3.wdata1 = 0;

    @(negedge clk);
    check("rst busy",       32'(b1.busy), 0);
    check("rst gnt/ack",    32'({b1.gnt0, b1.gnt1, b1.ack0, b1.ack1}), 0);
    check("rst mem",        32'({b1.mem_we, b1.mem_addr, b1.mem_d}), 0);
    check("rst rdata",      32'({b1.rdata0, b1.rdata1}), 0);
    check("rst last_grant", 32'(b1.last_grant), 1);
    rst = 1'b1;

    // Single write from requester 0.
    txn1(0, 1'b1, 8'h10, 16'hBEEF, ack_at, we_cnt, bad);
    check("wr ack latency", ack_at, 2);
    check("wr we cycles",   we_cnt, 1);
    check("wr bad obs",     bad, 0);
    check("wr last_grant",  32'(b1.last_grant), 0);
    @(negedge clk);
    check("wr idle busy",   32'({b1.busy, b1.ack0}), 0);
    check("wr addr held",   32'({b1.mem_addr, b1.mem_d}), 32'h10BEEF);
    check("wr ram",         32'(ram1[8'h10]), 32'hBEEF);

    // Read-back by requester 1, then cross reads/writes to show rdata isolation.
    txn1(1, 1'b0, 8'h10, 16'h0, ack_at, we_cnt, bad);
    check("rd ack latency", ack_at, 2);
    check("rd we cycles",   we_cnt, 0);
    check("rd rdata1",      32'(b1.rdata1), 32'hBEEF);
    check("rd rdata0 kept", 32'(b1.rdata0), 0);
    check("rd last_grant",  32'(b1.last_grant), 1);
    @(negedge clk);
    txn1(0, 1'b0, 8'h10, 16'h0, ack_at, we_cnt, bad);
    check("rd0 rdata0",     32'(b1.rdata0), 32'hBEEF);
    @(negedge clk);
    txn1(1, 1'b1, 8'h10, 16'h5555, ack_at, we_cnt, bad);
    check("wr1 rdata kept", 32'({b1.rdata0, b1.rdata1}), 32'hBEEFBEEF);
    check("wr1 ram",        32'(ram1[8'h10]), 32'h5555);

    // Round robin straight after reset with both requesters held.
    @(negedge clk);
    rst = 1'b0;
    #1 rst = 1'b1;
    b1.we0 = 0; b1.we1 = 0; b1.addr0 = 8'h01; b1.addr1 = 8'h02;
    b1.req0 = 1'b1; b1.req1 = 1'b1;
    nacks = 0;
    for (int i = 0; i < 4; i++) begin order[i] = 9; lg[i] = 1'bx; end
    for (int c = 0; c < 40 && nacks < 4; c++) begin
      @(negedge clk);
      if (!b1.req0) b1.req0 = 1'b1;
      if (!b1.req1) b1.req1 = 1'b1;
      if (b1.ack0) begin order[nacks] = 0; lg[nacks] = b1.last_grant; nacks++; b1.req0 = 1'b0; end
      else if (b1.ack1) begin order[nacks] = 1; lg[nacks] = b1.last_grant; nacks++; b1.req1 = 1'b0; end
    end
    b1.req0 = 1'b0; b1.req1 = 1'b0;
    check("rr ack count", nacks, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr order", order[i], i % 2);
      check("rr last_grant", 32'(lg[i]), i % 2);
    end
    repeat (2) @(negedge clk);

    // HOLD=3: address change during ACCESS must not reach the RAM.
    b3.req0 = 1'b1; b3.we0 = 1'b1; b3.addr0 = 8'h20; b3.wdata0 = 16'h1234;
    ack_at = -1; we_cnt = 0; a20 = 0;
    for (int c = 1; c <= 10 && ack_at < 0; c++) begin
      @(negedge clk);
      if (c == 1) b3.addr0 = 8'h30;
      if (b3.mem_we) begin
        we_cnt++;
        if (b3.mem_addr == 8'h20) a20++;
      end
      if (b3.ack0) begin ack_at = c; b3.req0 = 1'b0; end
    end
    b3.req0 = 1'b0;
    check("h3 ack latency", ack_at, 4);
    check("h3 we cycles",   we_cnt, 3);
    check("h3 addr stable", a20, 3);
    check("h3 addr in done", 32'(b3.mem_addr), 32'h20);
    @(negedge clk);
    check("h3 ram20", 32'(ram3[8'h20]), 32'h1234);
    check("h3 ram30", 32'(ram3[8'h30]), 0);

    // Asynchronous reset in the middle of a HOLD=3 write.
    b3.req0 = 1'b1; b3.we0 = 1'b1; b3.addr0 = 8'h40; b3.wdata0 = 16'hAAAA;
    @(negedge clk);
    check("ar pre we", 32'({b3.mem_we, b3.gnt0, b3.busy}), 32'h7);
    #2 rst = 1'b0;
    #1;
    check("ar drop",       32'({b3.mem_we, b3.gnt0, b3.busy}), 0);
    check("ar last_grant", 32'(b3.last_grant), 1);
    b3.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (b3.ack0) acks++;
    end
    check("ar no ack", acks, 0);
    b3.we0 = 0; b3.we1 = 0;
    b3.req0 = 1'b1; b3.req1 = 1'b1;
    @(negedge clk);
    check("ar tie gnt", 32'({b3.gnt0, b3.gnt1}), 32'h2);
    b3.req0 = 1'b0; b3.req1 = 1'b0;
    repeat (6) @(negedge clk);

`ifdef ARB_ACCESS_COUNT_EN
    rst = 1'b0;
    #1 rst = 1'b1;
    check("cnt reset", 32'({b1.cnt0, b1.cnt1}), 0);
    for (int i = 0; i < 3; i++) begin
      txn1(0, 1'b0, 8'h00, 16'h0, ack_at, we_cnt, bad);
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      txn1(1, 1'b0, 8'h00, 16'h0, ack_at, we_cnt, bad);
      @(negedge clk);
    end
    check("cnt0", 32'(b1.cnt0), 3);
    check("cnt1", 32'(b1.cnt1), 2);
    u_dut.cnt0_q = 16'hFFFF;
    txn1(0, 1'b0, 8'h00, 16'h0, ack_at, we_cnt, bad);
    @(negedge clk);
    check("cnt0 sat", 32'(b1.cnt0), 32'hFFFF);
    check("cnt1 kept", 32'(b1.cnt1), 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
